// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner and its event consumers.
// The event payload carries a fixed-width key code so any scanner size fits one type.
package keypad_pkg;

    localparam int KEY_CODE_MAX_W = 8;
    localparam int DEF_ROWS       = 4;
    localparam int DEF_COLS       = 3;
    localparam int DEF_KW         = $clog2(DEF_ROWS * DEF_COLS);

    typedef struct packed {
        logic [KEY_CODE_MAX_W-1:0] code;
        logic                      press;
    } keypad_evt_t;

    // Flat key number of the switch at (row, col); consumers decode with the same rule.
    function automatic logic [KEY_CODE_MAX_W-1:0] key_index(input int row, input int col,
                                                            input int cols);
        return KEY_CODE_MAX_W'(row * cols + col);
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// First-word-fall-through event queue: the head entry is visible whenever the queue is non-empty.
// A push into a full queue is accepted only when a pop frees a slot in the same cycle.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  keypad_evt_t push_data,
    input  logic        pop,
    output keypad_evt_t head,
    output logic        empty,
    output logic        full
);

    localparam int AW = $clog2(DEPTH);

    keypad_evt_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty masks the head and pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scan matrix keypad controller: rotates a one-hot row drive, debounces each key on its
// row's sample cycle and queues press/release events for a consumer.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int COLS       = 3,
    parameter int ROWS       = 4,
    parameter int DEBOUNCE   = 5,
    parameter int SCAN_DIV   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [COLS-1:0]                 keypadc,
    output logic [ROWS-1:0]                 keypadr,
    output logic [ROWS*COLS-1:0]            keys,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [$clog2(ROWS*COLS)-1:0]    evt_code,
    output logic                            evt_press,
    output logic                            overflow
);

    localparam int NK  = ROWS * COLS;
    localparam int KW  = $clog2(NK);
    localparam int CW  = $clog2(DEBOUNCE + 1);
    localparam int DW  = $clog2(SCAN_DIV + 1);
    localparam int RW  = $clog2(ROWS);
    localparam int CCW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [ROWS-1:0] row_q;
    logic [ROWS-1:0] row_d;
    logic [DW-1:0]   dwell_q;
    logic [DW-1:0]   dwell_d;
    logic            row_ok;
    logic            sample;
    logic [RW-1:0]   row_idx;
    logic [KW-1:0]   key_base;

    logic [NK-1:0]   keys_q;
    logic [CW-1:0]   cnt_q [NK];
    logic [CW-1:0]   cur_cnt [COLS];
    logic [COLS-1:0] disagree;
    logic            commit_hit;
    logic [CCW-1:0]  commit_col;
    logic            overflow_q;

    keypad_evt_t     evt_data;
    keypad_evt_t     fifo_head;
    logic            evt_push;
    logic            fifo_empty;
    logic            fifo_full;

    assign row_ok = $onehot(row_q);

    // Scan FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= ROWS'(1);
            dwell_q <= '0;
        end else begin
            row_q   <= row_d;
            dwell_q <= dwell_d;
        end
    end

    // Scan FSM: next state; a corrupted row ring recovers to row 0 even while disabled
    always_comb begin
        row_d   = row_q;
        dwell_d = dwell_q;
        if (!row_ok) begin
            row_d   = ROWS'(1);
            dwell_d = '0;
        end else if (en) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                row_d   = {row_q[ROWS-2:0], row_q[ROWS-1]};
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    // Scan FSM: outputs
    always_comb begin
        keypadr = row_q;
        sample  = en && row_ok && (dwell_q == DWELL_LAST);
        row_idx = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_q[r]) row_idx = RW'(r);
        end
    end

    assign key_base = KW'(key_index(int'(row_idx), 0, COLS));

    // Descending scan so the lowest due column ends up as the single commit this sample.
    always_comb begin
        commit_hit = 1'b0;
        commit_col = '0;
        disagree   = '0;
        cur_cnt    = '{default: '0};
        for (int c = COLS - 1; c >= 0; c--) begin
            disagree[c] = keypadc[c] ^ keys_q[key_base + KW'(c)];
            cur_cnt[c]  = cnt_q[key_base + KW'(c)];
            if (disagree[c] && (cur_cnt[c] >= CNT_MAX)) begin
                commit_hit = 1'b1;
                commit_col = CCW'(c);
            end
        end
    end

    assign evt_push       = sample && commit_hit;
    assign evt_data.code  = key_index(int'(row_idx), int'(commit_col), COLS);
    assign evt_data.press = keypadc[commit_col];

    // Due keys that lose arbitration keep their count saturated and commit on a later visit.
    always_ff @(posedge clk) begin
        if (rst) begin
            keys_q     <= '0;
            overflow_q <= 1'b0;
            for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
        end else begin
            if (sample) begin
                for (int c = 0; c < COLS; c++) begin
                    if (!disagree[c]) begin
                        cnt_q[key_base + KW'(c)] <= '0;
                    end else if (cur_cnt[c] < CNT_MAX) begin
                        cnt_q[key_base + KW'(c)] <= cur_cnt[c] + 1'b1;
                    end else if (commit_hit && (commit_col == CCW'(c))) begin
                        cnt_q[key_base + KW'(c)]  <= '0;
                        keys_q[key_base + KW'(c)] <= ~keys_q[key_base + KW'(c)];
                    end
                end
            end
            if (evt_push && fifo_full && !evt_ready) overflow_q <= 1'b1;
        end
    end

    keypad_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (evt_push),
        .push_data(evt_data),
        .pop      (evt_ready),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign keys      = keys_q;
    assign evt_valid = !fifo_empty;
    assign evt_code  = KW'(fifo_head.code);
    assign evt_press = fifo_head.press;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a default-parameter instance checked through an event
// scoreboard, plus a slow-scan instance for enable/dwell behaviour.
module tb_keypad_matrix_scanner;
    import keypad_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 3;
    localparam int NK   = ROWS * COLS;
    localparam int KW   = $clog2(NK);

    typedef struct packed {
        logic [KW-1:0] code;
        logic          press;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b1;
    logic            evt_ready = 1'b1;
    logic [COLS-1:0] keypadc;
    logic [ROWS-1:0] keypadr;
    logic [NK-1:0]   keys;
    logic            evt_valid;
    logic [KW-1:0]   evt_code;
    logic            evt_press;
    logic            overflow;
    logic [NK-1:0]   pressed = '0;

    logic            en3 = 1'b0;
    logic            evt_ready3 = 1'b1;
    logic [COLS-1:0] keypadc3;
    logic [ROWS-1:0] keypadr3;
    logic [NK-1:0]   keys3;
    logic            evt_valid3;
    logic [KW-1:0]   evt_code3;
    logic            evt_press3;
    logic            overflow3;
    logic [NK-1:0]   pressed3 = '0;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              n0;
    logic            fired;
    logic [ROWS-1:0] saved_row;

    always #5 clk = ~clk;

    keypad_matrix_scanner u_dut (
        .clk(clk), .rst(rst), .en(en), .keypadc(keypadc), .keypadr(keypadr), .keys(keys),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_press(evt_press), .overflow(overflow)
    );

    keypad_matrix_scanner #(.DEBOUNCE(1), .SCAN_DIV(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .keypadc(keypadc3), .keypadr(keypadr3), .keys(keys3),
        .evt_valid(evt_valid3), .evt_ready(evt_ready3), .evt_code(evt_code3),
        .evt_press(evt_press3), .overflow(overflow3)
    );

    // Switch matrix: a closed key connects its row drive to its column sense line.
    always_comb begin
        keypadc  = '0;
        keypadc3 = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (keypadr[r] && pressed[r*COLS+c])   keypadc[c]  = 1'b1;
                if (keypadr3[r] && pressed3[r*COLS+c]) keypadc3[c] = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input int code, input logic press);
        exp_t e;
        e.code  = KW'(code);
        e.press = press;
        sb.push_back(e);
    endtask

    // Monitor: every accepted head event must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && evt_valid && evt_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got code=%0d press=%0d, expected no event",
                         evt_code, evt_press);
            end else begin
                e = sb.pop_front();
                if (evt_code !== e.code || evt_press !== e.press) begin
                    errors++;
                    $display("FAIL evt_order: got code=%0d press=%0d, expected code=%0d press=%0d",
                             evt_code, evt_press, e.code, e.press);
                end
            end
        end
    end

    initial begin
        // Reset in the middle of a scan
        step(3);
        rst = 1'b0;
        step(6);
        rst = 1'b1;
        step(2);
        chk("rst_keypadr", 32'(keypadr), 32'h1);
        chk("rst_keys", 32'(keys), 32'h0);
        chk("rst_evt_valid", 32'(evt_valid), 32'h0);
        chk("rst_evt_code", 32'(evt_code), 32'h0);
        chk("rst_evt_press", 32'(evt_press), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_keypadr3", 32'(keypadr3), 32'h1);
        rst = 1'b0;

        // Key "5": press then release, three row-1 samples are not enough to commit
        pressed[4] = 1'b1;
        expect_evt(4, 1'b1);
        step(12);
        chk("k5_not_early", 32'(keys), 32'h0);
        step(12);
        chk("k5_pressed", 32'(keys), 32'h010);
        pressed[4] = 1'b0;
        expect_evt(4, 1'b0);
        step(24);
        chk("k5_released", 32'(keys), 32'h0);

        // Bouncing key: never five consecutive disagreeing samples
        for (int i = 0; i < 8; i++) begin
            pressed[0] = ~pressed[0];
            step(8);
        end
        chk("bounce_keys", 32'(keys), 32'h0);

        // Two keys of row 3 closing together commit lowest column first
        pressed[9]  = 1'b1;
        pressed[11] = 1'b1;
        expect_evt(9, 1'b1);
        expect_evt(11, 1'b1);
        step(28);
        chk("simul_pressed", 32'(keys), 32'h0A00);
        pressed[9]  = 1'b0;
        pressed[11] = 1'b0;
        expect_evt(9, 1'b0);
        expect_evt(11, 1'b0);
        step(28);
        chk("simul_released", 32'(keys), 32'h0);
        chk("sb_drained_mid", 32'(sb.size()), 32'h0);

        // FIFO full: five events, four fit, the fifth is dropped
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            int k;
            case (i)
                0: k = 0;
                1: k = 4;
                2: k = 8;
                3: k = 9;
                default: k = 10;
            endcase
            pressed[k] = 1'b1;
            if (i < 4) expect_evt(k, 1'b1);
            step(24);
            if (i == 3) chk("full_no_ovf_yet", 32'(overflow), 32'h0);
        end
        chk("full_overflow", 32'(overflow), 32'h1);
        chk("full_keys", 32'(keys), 32'h0711);
        chk("full_head_code", 32'(evt_code), 32'h0);
        chk("full_head_press", 32'(evt_press), 32'h1);

        // Push and pop in the same cycle while full
        pressed[0] = 1'b0;
        expect_evt(0, 1'b0);
        n0    = 0;
        fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) begin
            if (keypadr == 4'b0001) begin
                n0++;
                if (n0 == 5) begin
                    evt_ready = 1'b1;
                    fired     = 1'b1;
                end
            end
            step(1);
        end
        evt_ready = 1'b0;
        chk("full_pop_window", 32'(fired), 32'h1);
        chk("full_pushpop_head", 32'(evt_code), 32'h4);
        chk("full_pushpop_keys", 32'(keys), 32'h0710);
        chk("full_overflow_sticky", 32'(overflow), 32'h1);
        evt_ready = 1'b1;
        step(8);
        chk("full_drained", 32'(evt_valid), 32'h0);
        chk("sb_drained_full", 32'(sb.size()), 32'h0);

        // Reset clears overflow and keys without producing events
        pressed = '0;
        rst     = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst2_overflow", 32'(overflow), 32'h0);
        chk("rst2_keys", 32'(keys), 32'h0);
        chk("rst2_evt_valid", 32'(evt_valid), 32'h0);

        // Slow scan: freeze mid-dwell, then finish the remaining dwell before sampling
        en3 = 1'b1;
        step(1);
        saved_row   = keypadr3;
        chk("dwell_row0", 32'(saved_row), 32'h1);
        en3         = 1'b0;
        pressed3[0] = 1'b1;
        step(10);
        chk("frozen_keypadr", 32'(keypadr3), 32'(saved_row));
        chk("frozen_keys", 32'(keys3), 32'h0);
        en3 = 1'b1;
        step(1);
        chk("resume_dwell_row", 32'(keypadr3), 32'(saved_row));
        chk("resume_dwell_keys", 32'(keys3), 32'h0);
        step(1);
        chk("resume_rotated", 32'(keypadr3), 32'h2);
        chk("resume_sampled", 32'(keys3), 32'h1);
        en3 = 1'b0;

        step(2);
        chk("sb_empty_end", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
